rv32_mem: RTL
=============

Name: rv32_mem

Overview:
Memory-access pipeline stage directly downstream of execute; consumes its registered result, store data, memory control and branch control. Drives the data-bus request, aligns load data, resolves branches against the prediction, and registers the writeback-bound result. A three-state FSM handles multi-cycle bus waits and a timeout counter aborts hung accesses.

Parameters:
TIMEOUT, 255, maximum wait cycles for data_ready_in before abort (1..255)

Ports:
clk in 1 clock
reset_n in 1 async active-low reset
stall_in in 1 hold output registers (from hazard)
flush_in in 1 squash instruction entering outputs
valid_in in 1 instruction valid
branch_predicted_taken_in in 1 fetch prediction
alu_non_zero_in in 1 branch condition
branch_op_in in 2 NEVER/ZERO/NON_ZERO/ALWAYS
mem_read_in in 1 load
mem_write_in in 1 store
mem_width_in in 2 BYTE/HALF/WORD
mem_zero_extend_in in 1 unsigned load
rd_in in 5 destination
rd_write_in in 1 writes rd
result_in in 32 ALU/CSR result, also address
rs2_value_in in 32 store data
branch_pc_in in 32 redirect target
data_address_out out 32 word-aligned bus address
data_read_out out 1 read strobe
data_write_out out 1 write strobe
data_write_mask_out out 4 byte lanes
data_write_value_out out 32 lane-replicated store data
data_read_value_in in 32 read data
data_ready_in in 1 access complete
busy_out out 1 stall request to hazard
bus_error_out out 1 one-cycle timeout pulse
branch_mispredicted_out out 1 redirect request
branch_pc_out out 32 redirect target
valid_out out 1 to writeback
rd_out out 5 to writeback
rd_write_out out 1 to writeback
rd_value_out out 32 to writeback

Behaviour:
- Reset (async, reset_n=0): state IDLE, counter 0, valid_out/rd_write_out/bus_error_out 0, rd_out 0, rd_value_out 0.
- access = valid_in & (mem_read_in | mem_write_in). Address = {result_in[31:2],2'b00}.
- Lanes: BYTE mask 1<<result_in[1:0], data byte replicated x4; HALF mask 0011/1100 by result_in[1], bit0 ignored, half replicated x2; WORD mask 1111, addr[1:0] ignored.
- Load: select byte/half by same offsets; sign-extend unless mem_zero_extend_in.
- FSM IDLE: strobes = access & !stall_in. If ready same cycle -> complete (zero-wait). Else -> WAIT, counter 0.
- WAIT: strobes held, counter++. busy_out=1. valid_out/rd_write_out register 0 (bubble). ready & !stall_in -> complete, IDLE. ready & stall_in -> latch read data, DONE. counter==TIMEOUT-1 without ready -> abort: bus_error_out pulses, instruction registers with rd_write_out=0, IDLE.
- DONE: no strobes, busy_out=0; on !stall_in register held data, IDLE.
- flush_in ignored in WAIT/DONE; elsewhere on !stall_in forces valid_out=0, rd_write_out=0.
- Non-access instructions: rd_value_out <= result_in, one-cycle latency.
- taken: NEVER 0, ZERO !alu_non_zero_in, NON_ZERO alu_non_zero_in, ALWAYS 1. branch_mispredicted_out = valid_in & (taken != branch_predicted_taken_in), combinational; branch_pc_out = branch_pc_in.

Decomposition:
- Package rv32_mem_pkg: width and branch-op encodings, FSM state enum.
- Sub-module rv32_mem_align: combinational lane mask/replication and load extract/extend.

Test Plan:
- LB, result_in=0x1003, read 0x80FFFFFF, ready same cycle -> address 0x1000, rd_value_out 0xFFFFFF80 next cycle.
- SH, result_in=0x2002, rs2=0x1234 -> mask 1100, data 0x12341234.
- LW, ready after 3 cycles -> busy_out 3 cycles, valid_out 0 during, then value.
- ready with stall_in=1 -> DONE, data delivered when stall_in drops.
- TIMEOUT=4, ready never -> bus_error_out pulse on 4th wait cycle, rd_write_out=0.
- ZERO branch, alu_non_zero=1, predicted taken -> branch_mispredicted_out=1.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: encodings, FSM states and access context shared by the memory stage
package rv32_mem_pkg;

    typedef enum logic [1:0] {WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD} width_e;
    typedef enum logic [1:0] {BR_NEVER, BR_ZERO, BR_NON_ZERO, BR_ALWAYS} branch_op_e;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Everything needed to finish an access after execute has moved on
    typedef struct packed {
        logic        read;
        logic        write;
        logic [1:0]  width;
        logic        zext;
        logic [4:0]  rd;
        logic        rd_write;
        logic [31:0] result;
        logic [31:0] store;
    } ctx_t;

    function automatic logic branch_taken(input logic [1:0] op, input logic non_zero);
        return op == BR_ALWAYS || (op == BR_ZERO && !non_zero) || (op == BR_NON_ZERO && non_zero);
    endfunction

endpackage

// File: rtl/rv32_mem_align.sv
// rv32_mem_align: store lane mask/replication and load byte/half extraction with extension
module rv32_mem_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  offset_i,
    input  logic        zero_extend_i,
    input  logic [31:0] store_i,
    input  logic [31:0] load_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lo_byte;
    logic [15:0] half;

    // Widths other than byte/half behave as a full word
    always_comb begin
        lo_byte = load_i[{offset_i, 3'b000} +: 8];
        half    = offset_i[1] ? load_i[31:16] : load_i[15:0];
        mask_o  = width_i == WIDTH_BYTE ? 4'b0001 << offset_i :
                  width_i == WIDTH_HALF ? (offset_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o = width_i == WIDTH_BYTE ? {4{store_i[7:0]}} :
                  width_i == WIDTH_HALF ? {2{store_i[15:0]}} : store_i;
        rdata_o = width_i == WIDTH_BYTE ? {{24{~zero_extend_i & lo_byte[7]}}, lo_byte} :
                  width_i == WIDTH_HALF ? {{16{~zero_extend_i & half[15]}}, half} : load_i;
    end

endmodule

// File: rtl/rv32_mem.sv
// rv32_mem: memory-access stage with bus wait/timeout FSM, branch resolution and writeback registers
module rv32_mem
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        valid_in,
    input  logic        branch_predicted_taken_in,
    input  logic        alu_non_zero_in,
    input  logic [1:0]  branch_op_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        busy_out,
    output logic        bus_error_out,
    output logic        branch_mispredicted_out,
    output logic [31:0] branch_pc_out,
    output logic        valid_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out
);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    ctx_t        ctx_q, ctx_d, in_ctx, cur;
    logic [31:0] held_q, held_d, load_v, val_q, val_d;
    logic        valid_q, valid_d, rdw_q, rdw_d, err_q, err_d;
    logic [4:0]  rd_q, rd_d;
    logic        access, idle, timeout;
    logic [31:0] done_val;

    assign in_ctx = '{read: mem_read_in, write: mem_write_in, width: mem_width_in,
                      zext: mem_zero_extend_in, rd: rd_in, rd_write: rd_write_in & valid_in,
                      result: result_in, store: rs2_value_in};
    assign access   = valid_in & (mem_read_in | mem_write_in);
    assign idle     = state_q == S_IDLE;
    assign cur      = idle ? in_ctx : ctx_q;
    assign timeout  = cnt_q == 8'(TIMEOUT - 1);
    assign done_val = cur.read ? load_v : cur.result;

    rv32_mem_align u_align (
        .width_i       (cur.width),
        .offset_i      (cur.result[1:0]),
        .zero_extend_i (cur.zext),
        .store_i       (cur.store),
        .load_i        (data_read_value_in),
        .mask_o        (data_write_mask_out),
        .wdata_o       (data_write_value_out),
        .rdata_o       (load_v)
    );

    assign data_address_out        = {cur.result[31:2], 2'b00};
    assign data_read_out           = idle ? access & ~stall_in & mem_read_in : state_q == S_WAIT & ctx_q.read;
    assign data_write_out          = idle ? access & ~stall_in & mem_write_in : state_q == S_WAIT & ctx_q.write;
    assign busy_out                = state_q == S_WAIT;
    assign bus_error_out           = err_q;
    assign branch_mispredicted_out = valid_in & (branch_taken(branch_op_in, alu_non_zero_in) != branch_predicted_taken_in);
    assign branch_pc_out           = branch_pc_in;
    assign valid_out               = valid_q;
    assign rd_out                  = rd_q;
    assign rd_write_out            = rdw_q;
    assign rd_value_out            = val_q;

    // Access sequencing and writeback register next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctx_d   = ctx_q;
        held_d  = held_q;
        valid_d = valid_q;
        rd_d    = rd_q;
        rdw_d   = rdw_q;
        val_d   = val_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (!stall_in) begin
                ctx_d = in_ctx;
                cnt_d = 8'd0;
                if (access && !data_ready_in) begin
                    state_d = S_WAIT;
                    valid_d = 1'b0;
                    rdw_d   = 1'b0;
                end else begin
                    valid_d = valid_in & ~flush_in;
                    rdw_d   = in_ctx.rd_write & ~flush_in;
                    rd_d    = rd_in;
                    val_d   = done_val;
                end
            end
            S_WAIT: begin
                cnt_d   = cnt_q + 8'd1;
                valid_d = 1'b0;
                rdw_d   = 1'b0;
                if (data_ready_in && !stall_in) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                    rd_d    = ctx_q.rd;
                    rdw_d   = ctx_q.rd_write;
                    val_d   = done_val;
                end else if (data_ready_in) begin
                    state_d = S_DONE;
                    held_d  = done_val;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    rd_d    = ctx_q.rd;
                    val_d   = ctx_q.result;
                end
            end
            S_DONE: if (!stall_in) begin
                state_d = S_IDLE;
                valid_d = 1'b1;
                rd_d    = ctx_q.rd;
                rdw_d   = ctx_q.rd_write;
                val_d   = held_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, context and writeback registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            ctx_q   <= '0;
            held_q  <= '0;
            valid_q <= 1'b0;
            rd_q    <= '0;
            rdw_q   <= 1'b0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctx_q   <= ctx_d;
            held_q  <= held_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            rdw_q   <= rdw_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

endmodule
